flag_gen_pipe: RTL
==================

Name: flag_gen_pipe

Overview:
- Two-stage pipelined producer of the zero/neg/ofl condition flags consumed by the set-instruction logic and the branch condition logic.
- Performs a 16-bit add/subtract on EX operands and registers the result and flags.
- Supports pipeline stall, flush and flag-write enable, so downstream set/branch logic always sees flags from the most recent flag-writing instruction.

Parameters:
- WIDTH, 16, datapath width of operands and result; flags are derived from bit WIDTH-1.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- valid_in  input  1  stage-1 input carries a live instruction
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0: result = a + b; 1: result = a - b (a + ~b + 1)
- flag_wr  input  1  instruction updates the architectural flags
- stall  input  1  hold both stages
- flush  input  1  kill both stages
- valid_out  output  1  stage-2 holds a live instruction
- result  output  WIDTH  stage-2 arithmetic result
- zero  output  1  architectural zero flag
- neg  output  1  architectural negative flag
- ofl  output  1  architectural signed-overflow flag
- cout  output  1  architectural carry-out flag

Behaviour:
- Reset: all stage registers, valid_out, result, zero, neg, ofl and cout are cleared to 0 on the first rising clk edge with rst=1. rst overrides stall and flush.
- Stage 1 (S1) register fields: v1, a1, b1, sub1, fw1. Captured from the inputs when not stalled.
- Stage 2 (S2) arithmetic is computed from the S1 registers:
  - bb = sub1 ? ~b1 : b1
  - {c, r} = a1 + bb + sub1, a (WIDTH+1)-bit sum
- S2 registers result <= r and valid_out <= v1 when not stalled.
- Flag computation:
  - z = (r == 0)
  - n = r[WIDTH-1]
  - o = (a1[W-1] == bb[W-1]) && (r[W-1] != a1[W-1])
  - carry = c
- Architectural flag registers (zero, neg, ofl, cout) load z/n/o/carry on the same edge that S2 loads, only when v1 && fw1 && !stall && !flush. Otherwise they hold their value.
- Latency: operands presented in cycle N appear on result/valid_out, and in the flags if enabled, after the edge ending cycle N+1 (2 edges). Throughput is one instruction per cycle.
- Stall (stall=1, flush=0): S1, S2 and the flag registers all hold. Inputs presented that cycle are not captured; upstream must hold them.
- Flush (flush=1): v1 <= 0 and valid_out <= 0. The flag registers do not update that edge. Data fields are don't-care. Flush takes priority over stall.
- Bubble (valid_in=0): propagates as v=0. The flags never update from a bubble, even if flag_wr=1.
- flag_wr=0 with a valid instruction: result and valid_out update normally; the flags hold their previous values.
- Wrap-around: add/sub is modulo 2^WIDTH; overflow is reported only through ofl and cout, never saturated.
- Subtract edge cases:
  - a - b with a == b gives z=1, cout=1.
  - 0 - 1 gives r=0xFFFF, n=1, cout=0, o=0.
- Outputs are driven only from registers (no combinational path from inputs to outputs).

Test Plan:
- Reset then add: rst for 2 cycles, then a=0x0003, b=0x0004, sub=0, flag_wr=1, valid_in=1 -> 2 edges later result=0x0007, valid_out=1, zero=0, neg=0, ofl=0, cout=0. All outputs 0 while rst=1.
- Signed overflow: a=0x7FFF, b=0x0001 add -> result=0x8000, neg=1, ofl=1, cout=0. Then a=0x8000, b=0x0001 sub -> result=0x7FFF, ofl=1, neg=0, cout=1.
- Zero and flag hold: a=0x1234, b=0x1234 sub flag_wr=1 -> zero=1, cout=1. Next op a=0x0001, b=0x0001 add flag_wr=0 -> result=0x0002, zero stays 1, cout stays 1.
- Back-to-back with stall: issue three adds (1+1, 2+2, 3+3) on consecutive cycles, stall=1 for 2 cycles after the 2nd issue -> results 0x0002, 0x0004, 0x0006 appear in order exactly once each. valid_out and flags are frozen during the stall.
- Flush priority: with a valid flag-writing op (0xFFFF+0x0001) in S1, assert stall=1 and flush=1 together -> next edge valid_out=0, v1=0, flags unchanged (zero keeps its prior value).
- Reset mid-operation: valid ops in S1 and S2, then rst=1 for one edge together with stall=1 -> valid_out=0, result=0, all flags 0. The next op issued after reset completes with correct values.

Source files
------------

// File: rtl/flag_gen_pipe.sv
// -----------------------------------------------------------------------------
// flag_gen_pipe
// Two-stage pipelined add/subtract unit that produces the architectural
// zero/neg/ofl/cout condition flags used by set-instruction and branch logic.
//
// Stage 1 registers the EX operands and control. Stage 2 performs the
// (WIDTH+1)-bit add/subtract on the stage-1 registers, registers the result,
// and loads the architectural flags when the instruction is live and
// flag-writing.
//
// Ports:
//   clk        system clock, all state updates on rising edge
//   rst        synchronous, active-high reset (overrides stall and flush)
//   valid_in   stage-1 input carries a live instruction
//   a, b       operands (WIDTH bits)
//   sub        0: a + b, 1: a - b (a + ~b + 1)
//   flag_wr    instruction updates the architectural flags
//   stall      hold both stages and the flags
//   flush      kill both stages (takes priority over stall)
//   valid_out  stage 2 holds a live instruction
//   result     stage-2 arithmetic result
//   zero, neg, ofl, cout  architectural condition flags
// -----------------------------------------------------------------------------
module flag_gen_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             flag_wr,
    input  logic             stall,
    input  logic             flush,
    output logic             valid_out,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             ofl,
    output logic             cout
);

    // Stage 1 registers
    logic             r_v1;
    logic [WIDTH-1:0] r_a1;
    logic [WIDTH-1:0] r_b1;
    logic             r_sub1;
    logic             r_fw1;

    // Stage 2 and architectural flag registers
    logic             r_valid_out;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_neg;
    logic             r_ofl;
    logic             r_cout;

    // Stage 2 arithmetic, computed from stage-1 registers
    logic [WIDTH-1:0] w_bb;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_r;
    logic             w_z;
    logic             w_n;
    logic             w_o;
    logic             w_c;

    assign w_bb  = r_sub1 ? ~r_b1 : r_b1;
    // sub1 doubles as the carry-in that completes the two's complement of b
    assign w_sum = {1'b0, r_a1} + {1'b0, w_bb} + {{WIDTH{1'b0}}, r_sub1};
    assign w_r   = w_sum[WIDTH-1:0];
    assign w_c   = w_sum[WIDTH];
    assign w_z   = (w_r == '0);
    assign w_n   = w_r[WIDTH-1];
    // Signed overflow: both addends share a sign and the result sign differs
    assign w_o   = (r_a1[WIDTH-1] == w_bb[WIDTH-1]) && (w_r[WIDTH-1] != r_a1[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1        <= 1'b0;
            r_a1        <= '0;
            r_b1        <= '0;
            r_sub1      <= 1'b0;
            r_fw1       <= 1'b0;
            r_valid_out <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_ofl       <= 1'b0;
            r_cout      <= 1'b0;
        end else if (flush) begin
            // Only the valid bits are killed; data fields are left as-is
            // and the flags never load on a flush edge.
            r_v1        <= 1'b0;
            r_valid_out <= 1'b0;
        end else if (!stall) begin
            r_v1        <= valid_in;
            r_a1        <= a;
            r_b1        <= b;
            r_sub1      <= sub;
            r_fw1       <= flag_wr;
            r_valid_out <= r_v1;
            r_result    <= w_r;
            // Bubbles and non-flag-writing ops leave the flags untouched
            if (r_v1 && r_fw1) begin
                r_zero <= w_z;
                r_neg  <= w_n;
                r_ofl  <= w_o;
                r_cout <= w_c;
            end
        end
    end

    assign valid_out = r_valid_out;
    assign result    = r_result;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign ofl       = r_ofl;
    assign cout      = r_cout;

endmodule
